// File: rtl/datapath_sequencer_4bits.sv
// rtl/datapath_sequencer_4bits.sv - multi-cycle controller for the 4-bit register-file/ULA datapath
module datapath_sequencer_4bits #(
  parameter int WIDTH = 4,
  parameter int OPW   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       cmd,
  input  logic [OPW-1:0]   alu_op,
  input  logic [1:0]       dst,
  input  logic [1:0]       src_a,
  input  logic [1:0]       src_b,
  input  logic [WIDTH-1:0] imm,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_q,
  output logic             carry_q,
  input  logic [WIDTH-1:0] dp_result,
  input  logic             dp_carry_out,
  output logic [1:0]       reg_addr,
  output logic             write_enable,
  output logic             sel12,
  output logic             sel21,
  output logic [OPW-1:0]   opcode,
  output logic             carry_in,
  output logic [WIDTH-1:0] dados
);

  localparam logic [3:0] S_IDLE = 4'd0;
  localparam logic [3:0] S_RDA  = 4'd1;
  localparam logic [3:0] S_LDA  = 4'd2;
  localparam logic [3:0] S_RDB  = 4'd3;
  localparam logic [3:0] S_LDB  = 4'd4;
  localparam logic [3:0] S_EXEC = 4'd5;
  localparam logic [3:0] S_WB_A = 4'd6;
  localparam logic [3:0] S_WB_I = 4'd7;
  localparam logic [3:0] S_DONE = 4'd8;

  localparam logic [1:0] CMD_LOADI = 2'b00;
  localparam logic [1:0] CMD_ALU   = 2'b01;
  localparam logic [1:0] CMD_ALUC  = 2'b10;

  logic [3:0]       state, state_n;
  logic             accept;
  logic [1:0]       cmd_l, dst_l, src_a_l, src_b_l;
  logic [1:0]       cmd_n, dst_n, src_a_n, src_b_n;
  logic [OPW-1:0]   op_l, op_n;
  logic [WIDTH-1:0] imm_l, imm_n;

  // Fields seen by the output decode: fresh inputs on the accept edge, latched copies afterwards.
  always_comb begin
    accept  = (state == S_IDLE) && start;
    cmd_n   = accept ? cmd    : cmd_l;
    dst_n   = accept ? dst    : dst_l;
    src_a_n = accept ? src_a  : src_a_l;
    src_b_n = accept ? src_b  : src_b_l;
    op_n    = accept ? alu_op : op_l;
    imm_n   = accept ? imm    : imm_l;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          case (cmd)
            CMD_LOADI:          state_n = S_WB_I;
            CMD_ALU, CMD_ALUC:  state_n = S_RDA;
            default:            state_n = S_DONE;
          endcase
        end
      end
      S_RDA:   state_n = S_LDA;
      S_LDA:   state_n = S_RDB;
      S_RDB:   state_n = S_LDB;
      S_LDB:   state_n = S_EXEC;
      S_EXEC:  state_n = S_WB_A;
      S_WB_A:  state_n = S_DONE;
      S_WB_I:  state_n = S_DONE;
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so each one is valid for the whole state it belongs to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      cmd_l        <= '0;
      dst_l        <= '0;
      src_a_l      <= '0;
      src_b_l      <= '0;
      op_l         <= '0;
      imm_l        <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      result_q     <= '0;
      carry_q      <= 1'b0;
      reg_addr     <= '0;
      write_enable <= 1'b0;
      sel12        <= 1'b0;
      sel21        <= 1'b0;
      opcode       <= '0;
      carry_in     <= 1'b0;
      dados        <= '0;
    end else begin
      state        <= state_n;
      cmd_l        <= cmd_n;
      dst_l        <= dst_n;
      src_a_l      <= src_a_n;
      src_b_l      <= src_b_n;
      op_l         <= op_n;
      imm_l        <= imm_n;
      busy         <= (state_n != S_IDLE);
      done         <= (state_n == S_DONE);
      write_enable <= (state_n == S_WB_A) || (state_n == S_WB_I);
      sel21        <= (state_n == S_WB_A);
      // EXEC keeps addressing B so a free-running operand load path keeps r2 intact.
      sel12        <= (state_n == S_RDB) || (state_n == S_LDB) ||
                      (state_n == S_EXEC) || (state_n == S_WB_A);
      dados        <= (state_n == S_WB_I) ? imm_n : '0;

      case (state_n)
        S_RDA, S_LDA:          reg_addr <= src_a_n;
        S_RDB, S_LDB, S_EXEC:  reg_addr <= src_b_n;
        S_WB_A, S_WB_I:        reg_addr <= dst_n;
        default:               reg_addr <= '0;
      endcase

      if (state_n == S_EXEC) begin
        opcode   <= op_n;
        carry_in <= (cmd_n == CMD_ALUC) ? carry_q : 1'b0;
      end else if (state_n != S_WB_A) begin
        opcode   <= '0;
        carry_in <= 1'b0;
      end

      if (state == S_EXEC) begin
        result_q <= dp_result;
        carry_q  <= dp_carry_out;
      end else if (state == S_WB_I) begin
        result_q <= imm_l;
      end
    end
  end

endmodule

// File: tb/tb_datapath_sequencer_4bits.sv
// tb/tb_datapath_sequencer_4bits.sv - randomized bench with datapath and architectural models
module tb_datapath_sequencer_4bits;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [1:0] cmd = '0, dst = '0, src_a = '0, src_b = '0;
  logic [2:0] alu_op = '0;
  logic [3:0] imm = '0;
  logic       busy, done, carry_q, write_enable, sel12, sel21, carry_in, dp_carry_out;
  logic [3:0] result_q, dados, dp_result;
  logic [1:0] reg_addr;
  logic [2:0] opcode;

  always #5 clk = ~clk;

  datapath_sequencer_4bits dut (
    .clk(clk), .rst(rst), .start(start), .cmd(cmd), .alu_op(alu_op), .dst(dst),
    .src_a(src_a), .src_b(src_b), .imm(imm), .busy(busy), .done(done),
    .result_q(result_q), .carry_q(carry_q), .dp_result(dp_result),
    .dp_carry_out(dp_carry_out), .reg_addr(reg_addr), .write_enable(write_enable),
    .sel12(sel12), .sel21(sel21), .opcode(opcode), .carry_in(carry_in), .dados(dados)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] ula(input logic [2:0] op, input logic [3:0] a,
                                     input logic [3:0] b, input logic cin);
    case (op)
      3'd0:    return {1'b0, a} + {1'b0, b} + {4'd0, cin};
      3'd1:    return {1'b0, a} + {1'b0, ~b} + 5'd1;
      3'd2:    return {1'b0, a & b};
      3'd3:    return {1'b0, a | b};
      3'd4:    return {1'b0, a ^ b};
      3'd5:    return {1'b0, ~a};
      3'd6:    return {1'b0, a};
      default: return {1'b0, b};
    endcase
  endfunction

  // Datapath: registered-read register file, demux into r1/r2, combinational ULA, write mux.
  logic [3:0] regs [4];
  logic [3:0] rd_q, r1, r2;
  logic       dp_clr = 1'b1;

  always_comb {dp_carry_out, dp_result} = ula(opcode, r1, r2, carry_in);

  always @(posedge clk) begin
    rd_q <= regs[reg_addr];
    if (sel12) r2 <= rd_q;
    else       r1 <= rd_q;
    if (dp_clr) begin
      for (int i = 0; i < 4; i++) regs[i] <= 4'd0;
    end else if (write_enable) begin
      regs[reg_addr] <= sel21 ? dp_result : dados;
    end
  end

  // Architectural model: rem counts cycles left until the done cycle (1 = done).
  int         rem = 0;
  logic [1:0] m_cmd, m_dst, m_a, m_b;
  logic [2:0] m_op;
  logic [3:0] m_imm, m_result;
  logic       m_carry, m_cin;
  logic [4:0] m_alu;
  logic [3:0] arch [4];

  initial begin
    m_result = 4'd0;
    m_carry = 1'b0;
    m_cin = 1'b0;
    m_cmd = 2'd0; m_dst = 2'd0; m_a = 2'd0; m_b = 2'd0; m_op = 3'd0; m_imm = 4'd0;
    m_alu = 5'd0;
    for (int i = 0; i < 4; i++) arch[i] = 4'd0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        rem = 0;
        m_result = 4'd0;
        m_carry = 1'b0;
      end else if (rem > 0) begin
        rem--;
        if (rem == 1) begin
          if (m_cmd == 2'd0) begin
            arch[m_dst] = m_imm;
            m_result = m_imm;
          end else begin
            arch[m_dst] = m_alu[3:0];
            m_result = m_alu[3:0];
            m_carry = m_alu[4];
          end
        end
      end else if (start) begin
        m_cmd = cmd; m_dst = dst; m_a = src_a; m_b = src_b; m_op = alu_op; m_imm = imm;
        m_cin = (cmd == 2'd2) ? m_carry : 1'b0;
        m_alu = ula(alu_op, arch[src_a], arch[src_b], m_cin);
        rem = (cmd == 2'd0) ? 2 : (cmd == 2'd3) ? 1 : 7;
      end
    end
  end

  int   done_cnt = 0;
  logic last_cin = 1'b0;

  initial forever begin
    @(negedge clk);
    if (!rst) begin
      logic alu;
      alu = (rem > 0) && (m_cmd == 2'd1 || m_cmd == 2'd2);
      chk("busy", int'(busy), int'(rem > 0));
      chk("done", int'(done), int'(rem == 1));
      chk("write_enable", int'(write_enable), int'(rem == 2));
      if (done) done_cnt++;
      if (rem <= 1) begin
        chk("result_q", int'(result_q), int'(m_result));
        chk("carry_q", int'(carry_q), int'(m_carry));
      end
      if (alu && rem >= 6) begin
        chk("rd_a_addr", int'(reg_addr), int'(m_a));
        chk("rd_a_sel12", int'(sel12), 0);
      end
      if (alu && (rem == 5 || rem == 4)) begin
        chk("rd_b_addr", int'(reg_addr), int'(m_b));
        chk("rd_b_sel12", int'(sel12), 1);
      end
      if (alu && (rem == 3 || rem == 2)) begin
        chk("opcode", int'(opcode), int'(m_op));
        chk("carry_in", int'(carry_in), int'(m_cin));
        if (rem == 3) last_cin = carry_in;
      end
      if (alu && rem == 2) begin
        chk("wb_a_addr", int'(reg_addr), int'(m_dst));
        chk("wb_a_sel21", int'(sel21), 1);
        chk("wb_a_sel12", int'(sel12), 1);
      end
      if (rem == 2 && m_cmd == 2'd0) begin
        chk("wb_i_addr", int'(reg_addr), int'(m_dst));
        chk("wb_i_sel21", int'(sel21), 0);
        chk("wb_i_dados", int'(dados), int'(m_imm));
      end
      if (rem == 1 && m_cmd != 2'd3) chk("regfile", int'(regs[m_dst]), int'(arch[m_dst]));
    end
  end

  task automatic issue(input logic [1:0] c, input logic [2:0] op, input logic [1:0] d,
                       input logic [1:0] a, input logic [1:0] b, input logic [3:0] im,
                       output int lat);
    int n;
    n = 0;
    while (busy && n < 40) begin @(posedge clk); #1; n++; end
    cmd = c; alu_op = op; dst = d; src_a = a; src_b = b; imm = im; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 1;
    while (!done && n < 20) begin @(posedge clk); #1; n++; end
    lat = n;
    chk("done_seen", int'(done), 1);
    @(posedge clk); #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_result_q"}, int'(result_q), 0);
    chk({tag, "_carry_q"}, int'(carry_q), 0);
    chk({tag, "_reg_addr"}, int'(reg_addr), 0);
    chk({tag, "_we"}, int'(write_enable), 0);
    chk({tag, "_sel12"}, int'(sel12), 0);
    chk({tag, "_sel21"}, int'(sel21), 0);
    chk({tag, "_opcode"}, int'(opcode), 0);
    chk({tag, "_carry_in"}, int'(carry_in), 0);
    chk({tag, "_dados"}, int'(dados), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, d0;
    logic [3:0] old;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;
    dp_clr = 1'b0;

    issue(2'd0, 3'd0, 2'd0, 2'd0, 2'd0, 4'd7, lat);
    chk("loadi_lat", lat, 2);
    chk("loadi_result", int'(result_q), 7);
    chk("loadi_reg0", int'(regs[0]), 7);

    issue(2'd0, 3'd0, 2'd0, 2'd0, 2'd0, 4'd5, lat);
    issue(2'd0, 3'd0, 2'd1, 2'd0, 2'd0, 4'd3, lat);
    issue(2'd1, 3'd0, 2'd2, 2'd0, 2'd1, 4'd0, lat);
    chk("alu_lat", lat, 7);
    chk("add_result", int'(result_q), 8);
    chk("add_carry", int'(carry_q), 0);
    chk("add_reg2", int'(regs[2]), 8);

    issue(2'd0, 3'd0, 2'd0, 2'd0, 2'd0, 4'd15, lat);
    issue(2'd0, 3'd0, 2'd1, 2'd0, 2'd0, 4'd1, lat);
    issue(2'd1, 3'd0, 2'd3, 2'd0, 2'd1, 4'd0, lat);
    chk("wrap_result", int'(result_q), 0);
    chk("wrap_carry", int'(carry_q), 1);
    issue(2'd2, 3'd0, 2'd3, 2'd0, 2'd1, 4'd0, lat);
    chk("aluc_cin", int'(last_cin), 1);
    chk("aluc_result", int'(result_q), 1);
    chk("aluc_carry", int'(carry_q), 1);

    issue(2'd0, 3'd0, 2'd0, 2'd0, 2'd0, 4'd5, lat);
    issue(2'd0, 3'd0, 2'd1, 2'd0, 2'd0, 4'd5, lat);
    issue(2'd1, 3'd1, 2'd0, 2'd0, 2'd1, 4'd0, lat);
    chk("sub_result", int'(result_q), 0);
    chk("sub_reg0", int'(regs[0]), 0);

    // start held high throughout an ALU instruction; fields scrambled while busy
    d0 = done_cnt;
    cmd = 2'd1; alu_op = 3'd0; dst = 2'd2; src_a = 2'd0; src_b = 2'd1; start = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 7; i++) begin
      cmd = 2'($urandom_range(0, 3)); alu_op = 3'($urandom_range(0, 7));
      dst = 2'($urandom_range(0, 3)); src_a = 2'($urandom_range(0, 3));
      src_b = 2'($urandom_range(0, 3)); imm = 4'($urandom_range(0, 15));
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk("spam_done_count", done_cnt - d0, 1);
    chk("spam_reg2", int'(regs[2]), 5);
    @(posedge clk); #1;
    chk("spam_idle", int'(busy), 0);

    // reset during EXEC
    old = regs[3];
    d0 = done_cnt;
    cmd = 2'd1; alu_op = 3'd0; dst = 2'd3; src_a = 2'd1; src_b = 2'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("pre_abort_opcode_phase", int'(busy), 1);
    #1 rst = 1'b1;
    #1;
    chk_all_zero("abort");
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("abort_no_done", done_cnt - d0, 0);
    chk("abort_reg3", int'(regs[3]), int'(old));

    issue(2'd3, 3'd0, 2'd0, 2'd0, 2'd0, 4'd9, lat);
    chk("rsv_lat", lat, 1);
    chk("rsv_result", int'(result_q), 0);

    for (int k = 0; k < 150; k++) begin
      issue(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
            2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), lat);
      chk("rand_lat", lat, (m_cmd == 2'd0) ? 2 : (m_cmd == 2'd3) ? 1 : 7);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
